// File: rtl/clk_div_sched_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_sched_pkg
//   Shared definitions for the programmable clock divider controller:
//   controller state encoding and the smallest legal divide ratio.
// ---------------------------------------------------------------------------
package clk_div_sched_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,  // output held low, counter parked at 0
    RUN     = 2'd1,  // counting with cur_div
    PENDING = 2'd2   // counting, new ratio waits for the period boundary
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage : clk_div_sched_pkg

// File: rtl/clk_div_core.sv
// ---------------------------------------------------------------------------
// clk_div_core
//   Period counter, 50%-duty waveform generation and end-of-period tick.
//   All inputs are the controller's *next-state* view, so every output flop
//   lines up with the cycle the controller is actually in.
//
//   Ports
//     clock_in  : source clock (posedge logic plus one negedge flop)
//     reset_n   : asynchronous active-low reset
//     run_i     : controller will be RUN/PENDING next cycle
//     div_i     : divide ratio that applies next cycle (>= 2)
//     load_i    : restart the count at 0 next cycle (start or boundary)
//     tick_o    : high on the last source cycle of each divided period
//     clock_o   : divided clock, 50% duty for even and odd ratios
// ---------------------------------------------------------------------------
module clk_div_core #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  output logic             tick_o,
  output logic             clock_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half;
  logic             p_q, p_d;
  logic             n_q;
  logic             tick_q, tick_d;
  logic             odd_q;

  // NOTE: every variable written here gets a value before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // ceil(div/2) written as floor + lsb, so div = 2^DIV_W-1 cannot overflow.
    half   = (div_i >> 1) + {{(DIV_W-1){1'b0}}, div_i[0]};
    cnt_d  = (run_i && !load_i) ? cnt_q + DIV_W'(1) : '0;
    p_d    = run_i && (cnt_d < half);
    tick_d = run_i && (cnt_d == div_i - DIV_W'(1));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      p_q    <= 1'b0;
      tick_q <= 1'b0;
      odd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      tick_q <= tick_d;
      odd_q  <= div_i[0];
    end
  end

  // Half-cycle delayed copy of p: AND-ing it in trims half a source cycle
  // from the front of the high phase, giving N/2 high time for odd N.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  assign tick_o  = tick_q;
  assign clock_o = odd_q ? (p_q & n_q) : p_q;

endmodule : clk_div_core

// File: rtl/clk_div_sched.sv
// ---------------------------------------------------------------------------
// clk_div_sched
//   Runtime-programmable clock divider controller. Sequences ratio changes,
//   starts and stops on period boundaries so clock_out_div never shows a
//   runt pulse or a truncated period.
//
//   Ports
//     clock_in      : source clock
//     reset_n       : asynchronous active-low reset
//     enable        : run request (level)
//     cfg_div       : requested divide ratio N
//     cfg_valid     : cfg_div is valid
//     cfg_ready     : a configuration can be accepted (not PENDING)
//     cfg_err       : 1-cycle pulse after an accepted N below 2
//     cur_div       : ratio currently applied
//     running       : controller is RUN or PENDING
//     clock_out_div : divided clock, 50% duty
//     tick          : pulse on the last source cycle of each divided period
// ---------------------------------------------------------------------------
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             clock_out_div,
  output logic             tick
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer;
  logic             cfg_ok;
  logic             boundary;
  logic             core_load;
  logic             core_run;

  assign xfer   = cfg_valid & cfg_ready;
  assign cfg_ok = xfer & (cfg_div >= DIV_W'(MIN_DIV));

  // ---- state register ----------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= STOPPED;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // ---- next-state logic --------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = xfer & ~cfg_ok;

    case (state_q)
      STOPPED: begin
        // A ratio accepted on the start cycle is the one RUN starts with.
        if (cfg_ok) cur_div_d = cfg_div;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (boundary && !enable) begin
          // Stop wins at the boundary; a ratio arriving on that same cycle
          // is applied directly instead of being parked.
          state_d = STOPPED;
          if (cfg_ok) cur_div_d = cfg_div;
        end else if (cfg_ok) begin
          state_d    = PENDING;
          pend_div_d = cfg_div;
        end
      end
      PENDING: begin
        if (boundary) begin
          cur_div_d = pend_div_q;
          state_d   = enable ? RUN : STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  // ---- outputs -----------------------------------------------------------
  always_comb begin
    cfg_ready = (state_q != PENDING);
    running   = (state_q != STOPPED);
  end

  assign cfg_err = cfg_err_q;
  assign cur_div = cur_div_q;

  // The core sees next-state values; a fresh count starts on every start
  // and on every boundary (where a new ratio may take effect).
  assign core_run  = (state_d != STOPPED);
  assign core_load = boundary | (state_q == STOPPED);

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .run_i    (core_run),
    .div_i    (cur_div_d),
    .load_i   (core_load),
    .tick_o   (tick),
    .clock_o  (clock_out_div)
  );

  // tick is high exactly on the boundary cycle, so it doubles as the
  // controller's boundary indicator.
  assign boundary = tick;

endmodule : clk_div_sched

// File: tb/tb_clk_div_sched.sv
// ---------------------------------------------------------------------------
// tb_clk_div_sched
//   Self-checking bench for clk_div_sched. A behavioural model tracks the
//   divided period as (active, phase, ratio, pending ratio) and predicts
//   every output, including the divided clock in both halves of each source
//   cycle, under directed scenarios and randomized stimulus.
// ---------------------------------------------------------------------------
module tb_clk_div_sched;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic [DIV_W-1:0] cur_div;
  logic             running;
  logic             clock_out_div;
  logic             tick;

  clk_div_sched #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock_in      (clock_in),
    .reset_n       (reset_n),
    .enable        (enable),
    .cfg_div       (cfg_div),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .cur_div       (cur_div),
    .running       (running),
    .clock_out_div (clock_out_div),
    .tick          (tick)
  );

  always #5 clock_in = ~clock_in;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---- behavioural model -------------------------------------------------
  bit m_active;   // divided clock is being produced
  bit m_pend_v;   // a new ratio is waiting for the end of the period
  int m_pend;
  int m_div;
  int m_ph;       // source-cycle position inside the current period
  bit m_err;

  task automatic model_reset();
    m_active = 1'b0;
    m_pend_v = 1'b0;
    m_pend   = 0;
    m_div    = DEFAULT_DIV;
    m_ph     = 0;
    m_err    = 1'b0;
  endtask

  // Advance the model by one source cycle using the inputs seen at the edge.
  task automatic model_step();
    bit xfer, ok, at_end;
    xfer   = cfg_valid && !m_pend_v;
    ok     = xfer && (int'(cfg_div) >= 2);
    at_end = m_active && (m_ph == m_div - 1);
    m_err  = xfer && !ok;
    if (!m_active) begin
      if (ok) m_div = int'(cfg_div);
      if (enable) m_active = 1'b1;
      m_ph = 0;
    end else if (at_end) begin
      m_ph = 0;
      if (m_pend_v) begin
        m_div    = m_pend;
        m_pend_v = 1'b0;
        m_active = enable;
      end else if (!enable) begin
        m_active = 1'b0;
        if (ok) m_div = int'(cfg_div);
      end else if (ok) begin
        m_pend_v = 1'b1;
        m_pend   = int'(cfg_div);
      end
    end else begin
      m_ph++;
      if (ok) begin
        m_pend_v = 1'b1;
        m_pend   = int'(cfg_div);
      end
    end
  endtask

  // High for the first ceil(N/2) source cycles; for odd N the rise is
  // delayed by half a source cycle, giving N/2 cycles of high time.
  function automatic bit exp_clk(input bit second_half);
    int h;
    h = (m_div + 1) / 2;
    if (!m_active) return 1'b0;
    if ((m_div % 2 == 1) && !second_half) return (m_ph >= 1) && (m_ph < h);
    return m_ph < h;
  endfunction

  // ---- stimulus helpers --------------------------------------------------
  task automatic cycle(input bit en, input bit v, input int d);
    enable    = en;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    @(posedge clock_in);
    model_step();
    #1;
    check("running",   32'(running),       32'(m_active));
    check("cfg_ready", 32'(cfg_ready),     32'(!m_pend_v));
    check("cur_div",   32'(cur_div),       32'(m_div));
    check("cfg_err",   32'(cfg_err),       32'(m_err));
    check("tick",      32'(tick),          32'(m_active && (m_ph == m_div - 1)));
    check("clk_hi1",   32'(clock_out_div), 32'(exp_clk(1'b0)));
    @(negedge clock_in);
    #1;
    check("clk_hi2",   32'(clock_out_div), 32'(exp_clk(1'b1)));
  endtask

  task automatic check_reset_values();
    check("rst_clk",     32'(clock_out_div), 32'd0);
    check("rst_tick",    32'(tick),          32'd0);
    check("rst_running", 32'(running),       32'd0);
    check("rst_ready",   32'(cfg_ready),     32'd1);
    check("rst_err",     32'(cfg_err),       32'd0);
    check("rst_div",     32'(cur_div),       32'(m_div));
  endtask

  // Asserted in the second half of a source cycle, checked before any edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clock_in);
    @(negedge clock_in);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_stopped();
    for (int i = 0; i < 600 && m_active; i++) cycle(1'b0, 1'b0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
  endtask

  // ---- main sequence -----------------------------------------------------
  initial begin
    bit en;
    bit v;
    int d;
    int r;

    reset_n   = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    model_reset();
    @(posedge clock_in);
    @(negedge clock_in);
    #1;
    check_reset_values();
    reset_n = 1'b1;

    // Default ratio 2: toggle every source cycle, tick every 2nd.
    run(10);

    // Ratio 3 from STOPPED: 1.5-cycle high time.
    run_until_stopped();
    cycle(1'b0, 1'b1, 3);
    run(12);

    // Ratio 4, then 7 requested mid-period.
    run_until_stopped();
    cycle(1'b0, 1'b1, 4);
    run(2);
    cycle(1'b1, 1'b1, 7);
    run(18);

    // Illegal ratios 1 and 0: error pulse only.
    cycle(1'b1, 1'b1, 1);
    run(2);
    cycle(1'b1, 1'b1, 0);
    run(8);

    // Ratio 5, stop requested early in the period.
    run_until_stopped();
    cycle(1'b0, 1'b1, 5);
    run(2);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0);

    // Enable re-asserted before the boundary cancels the stop.
    run(3);
    cycle(1'b0, 1'b0, 0);
    run(8);

    // Reset while 5 -> 9 is pending.
    run(2);
    cycle(1'b1, 1'b1, 9);
    cycle(1'b1, 1'b0, 0);
    do_reset();
    run(6);

    // Largest ratio: full count range without wrap-around trouble.
    run_until_stopped();
    cycle(1'b0, 1'b1, (1 << DIV_W) - 1);
    run(520);
    run_until_stopped();

    // Randomized traffic against the model.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      v = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)      d = $urandom_range(0, 1);
      else if (r == 1) d = $urandom_range(200, 255);
      else             d = $urandom_range(2, 9);
      cycle(en, v, d);
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_clk_div_sched
